// File: rtl/cache_valid_ctrl.sv
// cache_valid_ctrl
// ----------------------------------------------------------------------------
// Valid/dirty metadata array for a set-associative cache, with a flush
// sequencer that walks every line, hands dirty lines to the write-back path
// and invalidates the whole array.
//
// Ports
//   clk                 rising-edge clock
//   rst                 asynchronous active-low reset
//   rd_index            set to look up (combinational, zero latency)
//   valid_out/dirty_out valid/dirty bits of every way of set rd_index
//   set_we/set_way/set_index/set_dirty  mark a line valid (dirty = set_dirty)
//   clr_we/clr_way/clr_index            invalidate a line
//   flush_req           start a flush (sampled only while idle)
//   flush_busy          flush in progress
//   flush_done          one-cycle pulse at the end of a flush
//   wb_valid/wb_way/wb_index/wb_ready   dirty-line write-back handshake
// ----------------------------------------------------------------------------
module cache_valid_ctrl #(
    parameter int unsigned WAYS       = 4,
    parameter int unsigned TOTAL_SIZE = 16,
    parameter int unsigned DIRTY_EN   = 1,
    localparam int unsigned SETS   = TOTAL_SIZE / WAYS,
    localparam int unsigned WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1,
    localparam int unsigned IDX_W  = (SETS > 1) ? $clog2(SETS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rd_index,
    output logic [0:WAYS-1]  valid_out,
    output logic [0:WAYS-1]  dirty_out,
    input  logic             set_we,
    input  logic [WAY_W-1:0] set_way,
    input  logic [IDX_W-1:0] set_index,
    input  logic             set_dirty,
    input  logic             clr_we,
    input  logic [WAY_W-1:0] clr_way,
    input  logic [IDX_W-1:0] clr_index,
    input  logic             flush_req,
    output logic             flush_busy,
    output logic             flush_done,
    output logic             wb_valid,
    output logic [WAY_W-1:0] wb_way,
    output logic [IDX_W-1:0] wb_index,
    input  logic             wb_ready
);

    localparam int unsigned LINE_W   = (TOTAL_SIZE > 1) ? $clog2(TOTAL_SIZE) : 1;
    localparam bit          DIRTY_ON = (DIRTY_EN != 0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_WB   = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // Flat line number: lines of one set are contiguous (way-inner order).
    function automatic logic [LINE_W-1:0] line_of(input logic [IDX_W-1:0] idx,
                                                  input logic [WAY_W-1:0] way);
        return LINE_W'((int'(idx) % int'(SETS)) * int'(WAYS) + (int'(way) % int'(WAYS)));
    endfunction

    logic [TOTAL_SIZE-1:0] valid_q;
    logic [TOTAL_SIZE-1:0] dirty_q;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] ptr_idx_q;
    logic [WAY_W-1:0] ptr_way_q;

    logic             flush_busy_d, flush_done_d, wb_valid_d;
    logic [WAY_W-1:0] wb_way_d;
    logic [IDX_W-1:0] wb_index_d;

    logic [LINE_W-1:0] ptr_line_c;
    logic [LINE_W-1:0] set_line_c;
    logic [LINE_W-1:0] clr_line_c;
    logic              last_line_c;
    logic              line_dirty_c;
    logic              line_clr_c;
    logic              ptr_advance_c;

    assign ptr_line_c   = line_of(ptr_idx_q, ptr_way_q);
    assign set_line_c   = line_of(set_index, set_way);
    assign clr_line_c   = line_of(clr_index, clr_way);
    assign last_line_c  = (ptr_idx_q == IDX_W'(SETS - 1)) && (ptr_way_q == WAY_W'(WAYS - 1));
    assign line_dirty_c = valid_q[ptr_line_c] & dirty_q[ptr_line_c] & DIRTY_ON;

    // Zero-latency lookup of all ways of one set.
    always_comb begin
        valid_out = '0;
        dirty_out = '0;
        for (int w = 0; w < int'(WAYS); w++) begin
            valid_out[w] = valid_q[line_of(rd_index, WAY_W'(w))];
            dirty_out[w] = dirty_q[line_of(rd_index, WAY_W'(w))];
        end
    end

    // State register, line pointer and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            ptr_idx_q  <= '0;
            ptr_way_q  <= '0;
            flush_busy <= 1'b0;
            flush_done <= 1'b0;
            wb_valid   <= 1'b0;
            wb_way     <= '0;
            wb_index   <= '0;
        end else begin
            state_q    <= state_d;
            flush_busy <= flush_busy_d;
            flush_done <= flush_done_d;
            wb_valid   <= wb_valid_d;
            wb_way     <= wb_way_d;
            wb_index   <= wb_index_d;
            if (state_q == S_IDLE) begin
                ptr_idx_q <= '0;
                ptr_way_q <= '0;
            end else if (ptr_advance_c) begin
                if (ptr_way_q == WAY_W'(WAYS - 1)) begin
                    ptr_way_q <= '0;
                    ptr_idx_q <= ptr_idx_q + IDX_W'(1);
                end else begin
                    ptr_way_q <= ptr_way_q + WAY_W'(1);
                end
            end
        end
    end

    // Next-state logic; also decides when the scanned line gets invalidated.
    always_comb begin
        state_d       = state_q;
        line_clr_c    = 1'b0;
        ptr_advance_c = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (flush_req) state_d = S_SCAN;
            end
            S_SCAN: begin
                if (line_dirty_c) begin
                    state_d = S_WB;
                end else begin
                    line_clr_c = 1'b1;
                    if (last_line_c) state_d = S_DONE;
                    else             ptr_advance_c = 1'b1;
                end
            end
            S_WB: begin
                if (wb_ready) begin
                    line_clr_c = 1'b1;
                    if (last_line_c) begin
                        state_d = S_DONE;
                    end else begin
                        state_d       = S_SCAN;
                        ptr_advance_c = 1'b1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output decode from the next state, registered above.
    always_comb begin
        flush_busy_d = (state_d != S_IDLE);
        flush_done_d = (state_d == S_DONE);
        wb_valid_d   = (state_d == S_WB);
        wb_way_d     = wb_way;
        wb_index_d   = wb_index;
        // Capture the line address on entry to WB; it then holds until reused.
        if ((state_q == S_SCAN) && (state_d == S_WB)) begin
            wb_way_d   = ptr_way_q;
            wb_index_d = ptr_idx_q;
        end
    end

    // Metadata array. External writes only while idle; set wins over clear
    // on the same line because its assignment comes last.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (state_q == S_IDLE) begin
            if (clr_we) begin
                valid_q[clr_line_c] <= 1'b0;
                dirty_q[clr_line_c] <= 1'b0;
            end
            if (set_we) begin
                valid_q[set_line_c] <= 1'b1;
                dirty_q[set_line_c] <= set_dirty & DIRTY_ON;
            end
        end else if (line_clr_c) begin
            valid_q[ptr_line_c] <= 1'b0;
            dirty_q[ptr_line_c] <= 1'b0;
        end
    end

endmodule
